// File: rtl/gpio_multi.sv
// rtl/gpio_multi.sv - multi-channel memory-mapped GPIO with per-pin edge interrupts
//
// Ports:
//   ACLK, RESET_N         clock (rising edge), asynchronous active-low reset
//   ADDR, DATA_I, WRSTB   register write; byte address, ADDR[1:0] ignored
//   RDSTB, DATA_O         register read; DATA_O holds the read value for the one
//                         cycle after RDSTB and is 0 otherwise
//   GPIO_I                asynchronous pad inputs, channel c at [c*WIDTH +: WIDTH]
//   GPIO_O, GPIO_OE       pad output values and enables (1 = drive)
//   IRQ, IRQ_ANY          per-channel interrupt (|STATUS) and their OR
//
// Address map (offsets from BASEADDRESS):
//   c*32 + 0  DOUT   rw      c*32 + 16 CLR  wo (DOUT &= ~data)
//   c*32 + 4  DIR    rw      c*32 + 20 TGL  wo (DOUT ^= data)
//   c*32 + 8  DIN    ro      c*32 + 24 RISE_EN rw
//   c*32 + 12 SET    wo      c*32 + 28 FALL_EN rw
//   NCHAN*32 + 4*c   STATUS  write 1 to clear
module gpio_multi #(
    parameter logic [31:0] BASEADDRESS = 32'h8000_0000,
    parameter int          NCHAN       = 2,
    parameter int          WIDTH       = 18,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   ACLK,
    input  logic                   RESET_N,
    input  logic [31:0]            DATA_I,
    output logic [31:0]            DATA_O,
    input  logic [31:0]            ADDR,
    input  logic                   WRSTB,
    input  logic                   RDSTB,
    input  logic [NCHAN*WIDTH-1:0] GPIO_I,
    output logic [NCHAN*WIDTH-1:0] GPIO_O,
    output logic [NCHAN*WIDTH-1:0] GPIO_OE,
    output logic [NCHAN-1:0]       IRQ,
    output logic                   IRQ_ANY
);
    localparam int          NW       = NCHAN * WIDTH;
    localparam logic [31:0] REG_SPAN = 32'(NCHAN * 32);
    localparam logic [31:0] ALL_SPAN = 32'(NCHAN * 36);

    localparam logic [2:0] OFS_DOUT = 3'd0;
    localparam logic [2:0] OFS_DIR  = 3'd1;
    localparam logic [2:0] OFS_DIN  = 3'd2;
    localparam logic [2:0] OFS_SET  = 3'd3;
    localparam logic [2:0] OFS_CLR  = 3'd4;
    localparam logic [2:0] OFS_TGL  = 3'd5;
    localparam logic [2:0] OFS_RISE = 3'd6;
    localparam logic [2:0] OFS_FALL = 3'd7;

    logic [WIDTH-1:0] dout_q [NCHAN];
    logic [WIDTH-1:0] dir_q  [NCHAN];
    logic [WIDTH-1:0] rise_q [NCHAN];
    logic [WIDTH-1:0] fall_q [NCHAN];
    logic [WIDTH-1:0] stat_q [NCHAN];
    logic [NW-1:0]    sync_q [SYNC_STAGES];
    logic [NW-1:0]    prev_q;

    logic [31:0]      off;
    logic [31:0]      soff;
    logic             hit_reg;
    logic             hit_stat;
    logic [2:0]       ch;
    logic [2:0]       rofs;
    logic [2:0]       sch;
    logic [WIDTH-1:0] wdata;
    logic [NW-1:0]    din;
    logic [NW-1:0]    edge_set;
    logic [WIDTH-1:0] rd_pin;
    logic [31:0]      rdata;
    logic             unused_bits;

    // An address below BASEADDRESS wraps to a large offset and misses both windows.
    assign off      = ADDR - BASEADDRESS;
    assign soff     = off - REG_SPAN;
    assign hit_reg  = off < REG_SPAN;
    assign hit_stat = !hit_reg && (off < ALL_SPAN);
    assign ch       = off[7:5];
    assign rofs     = off[4:2];
    assign sch      = soff[4:2];
    assign wdata    = DATA_I[WIDTH-1:0];
    assign din      = sync_q[SYNC_STAGES-1];

    assign unused_bits = ^{DATA_I, soff};

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        // Edges are taken between the last synchroniser stage and its delayed copy.
        assign edge_set[c*WIDTH +: WIDTH] =
            (din[c*WIDTH +: WIDTH] & ~prev_q[c*WIDTH +: WIDTH] & rise_q[c]) |
            (~din[c*WIDTH +: WIDTH] & prev_q[c*WIDTH +: WIDTH] & fall_q[c]);
        assign GPIO_O[c*WIDTH +: WIDTH]  = dout_q[c];
        assign GPIO_OE[c*WIDTH +: WIDTH] = dir_q[c];
        assign IRQ[c]                    = |stat_q[c];
    end

    assign IRQ_ANY = |IRQ;

    always_comb begin
        rd_pin = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (hit_reg && ch == 3'(c)) begin
                case (rofs)
                    OFS_DOUT: rd_pin = dout_q[c];
                    OFS_DIR:  rd_pin = dir_q[c];
                    OFS_DIN:  rd_pin = din[c*WIDTH +: WIDTH];
                    OFS_RISE: rd_pin = rise_q[c];
                    OFS_FALL: rd_pin = fall_q[c];
                    default:  rd_pin = '0;
                endcase
            end
            if (hit_stat && sch == 3'(c)) begin
                rd_pin = stat_q[c];
            end
        end
        rdata              = '0;
        rdata[WIDTH-1:0]   = rd_pin;
    end

    always_ff @(posedge ACLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < NCHAN; c++) begin
                dout_q[c] <= '0;
                dir_q[c]  <= '0;
                rise_q[c] <= '0;
                fall_q[c] <= '0;
                stat_q[c] <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            DATA_O <= '0;
        end else begin
            sync_q[0] <= GPIO_I;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= din;
            // Read data comes from the pre-write register state.
            DATA_O <= RDSTB ? rdata : '0;
            for (int c = 0; c < NCHAN; c++) begin
                if (WRSTB && hit_reg && ch == 3'(c)) begin
                    case (rofs)
                        OFS_DOUT: dout_q[c] <= wdata;
                        OFS_DIR:  dir_q[c]  <= wdata;
                        OFS_SET:  dout_q[c] <= dout_q[c] | wdata;
                        OFS_CLR:  dout_q[c] <= dout_q[c] & ~wdata;
                        OFS_TGL:  dout_q[c] <= dout_q[c] ^ wdata;
                        OFS_RISE: rise_q[c] <= wdata;
                        OFS_FALL: fall_q[c] <= wdata;
                        default:  ;
                    endcase
                end
                // A new edge is ORed in after the clear, so it survives a same-cycle W1C.
                stat_q[c] <= (stat_q[c] & ~((WRSTB && hit_stat && sch == 3'(c)) ? wdata : '0))
                           | edge_set[c*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_gpio_multi.sv
// tb/tb_gpio_multi.sv - self-checking bench for gpio_multi
module tb_gpio_multi;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          NCHAN = 2;
    localparam int          WIDTH = 18;
    localparam int          SYNC  = 2;
    localparam int          NW    = NCHAN * WIDTH;
    localparam logic [31:0] WMASK = 32'h0003_FFFF;

    logic              ACLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [31:0]       DATA_I = '0;
    logic [31:0]       DATA_O;
    logic [31:0]       ADDR = '0;
    logic              WRSTB = 1'b0;
    logic              RDSTB = 1'b0;
    logic [NW-1:0]     GPIO_I = '0;
    logic [NW-1:0]     GPIO_O;
    logic [NW-1:0]     GPIO_OE;
    logic [NCHAN-1:0]  IRQ;
    logic              IRQ_ANY;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_multi #(
        .BASEADDRESS(BASE),
        .NCHAN(NCHAN),
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .ACLK(ACLK),
        .RESET_N(RESET_N),
        .DATA_I(DATA_I),
        .DATA_O(DATA_O),
        .ADDR(ADDR),
        .WRSTB(WRSTB),
        .RDSTB(RDSTB),
        .GPIO_I(GPIO_I),
        .GPIO_O(GPIO_O),
        .GPIO_OE(GPIO_OE),
        .IRQ(IRQ),
        .IRQ_ANY(IRQ_ANY)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: register file per channel plus a history of pin samples.
    // hist[j] is GPIO_I as sampled j+1 edges ago; DIN lags the pins by SYNC-1 edges.
    logic [31:0]   m_dout [NCHAN];
    logic [31:0]   m_dir  [NCHAN];
    logic [31:0]   m_rise [NCHAN];
    logic [31:0]   m_fall [NCHAN];
    logic [31:0]   m_stat [NCHAN];
    logic [NW-1:0] hist   [0:8];
    logic [31:0]   m_rd;

    function automatic logic [31:0] pins_of(input logic [NW-1:0] v, input int c);
        return 32'(v >> (c * WIDTH)) & WMASK;
    endfunction

    always @(posedge ACLK or negedge RESET_N) begin
        longint unsigned a;
        longint unsigned b;
        int              kind;
        int              ch;
        int              rg;
        logic [31:0]     wd;
        logic [31:0]     setv [NCHAN];
        logic [NW-1:0]   cur;
        logic [NW-1:0]   old;
        if (!RESET_N) begin
            for (int c = 0; c < NCHAN; c++) begin
                m_dout[c] = 0; m_dir[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_stat[c] = 0;
            end
            for (int j = 0; j <= 8; j++) hist[j] = '0;
            m_rd = 0;
        end else begin
            a = {32'b0, ADDR};
            b = {32'b0, BASE};
            kind = 0; ch = 0; rg = 0;
            if (a >= b && a < b + NCHAN * 32) begin
                kind = 1; ch = int'((a - b) / 32); rg = int'(((a - b) % 32) / 4);
            end else if (a >= b + NCHAN * 32 && a < b + NCHAN * 36) begin
                kind = 2; ch = int'((a - b - NCHAN * 32) / 4);
            end
            cur = hist[SYNC-1];
            old = hist[SYNC];
            m_rd = 0;
            if (RDSTB && kind == 1) begin
                case (rg)
                    0: m_rd = m_dout[ch];
                    1: m_rd = m_dir[ch];
                    2: m_rd = pins_of(cur, ch);
                    6: m_rd = m_rise[ch];
                    7: m_rd = m_fall[ch];
                    default: m_rd = 0;
                endcase
            end else if (RDSTB && kind == 2) begin
                m_rd = m_stat[ch];
            end
            for (int c = 0; c < NCHAN; c++) begin
                setv[c] = (pins_of(cur & ~old, c) & m_rise[c]) | (pins_of(~cur & old, c) & m_fall[c]);
            end
            wd = DATA_I & WMASK;
            if (WRSTB && kind == 1) begin
                case (rg)
                    0: m_dout[ch] = wd;
                    1: m_dir[ch]  = wd;
                    3: m_dout[ch] = m_dout[ch] | wd;
                    4: m_dout[ch] = m_dout[ch] & ~wd;
                    5: m_dout[ch] = m_dout[ch] ^ wd;
                    6: m_rise[ch] = wd;
                    7: m_fall[ch] = wd;
                    default: ;
                endcase
            end
            for (int c = 0; c < NCHAN; c++) begin
                if (WRSTB && kind == 2 && ch == c) m_stat[c] = m_stat[c] & ~wd;
                m_stat[c] = m_stat[c] | setv[c];
            end
            for (int j = 8; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = GPIO_I;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NW-1:0]    eo;
        logic [NW-1:0]    eoe;
        logic [NCHAN-1:0] eirq;
        for (int c = 0; c < NCHAN; c++) begin
            eo[c*WIDTH +: WIDTH]  = m_dout[c][WIDTH-1:0];
            eoe[c*WIDTH +: WIDTH] = m_dir[c][WIDTH-1:0];
            eirq[c]               = (m_stat[c] != 0);
        end
        chk({tag, ".gpio_o"},  64'(GPIO_O),  64'(eo));
        chk({tag, ".gpio_oe"}, 64'(GPIO_OE), 64'(eoe));
        chk({tag, ".irq"},     64'(IRQ),     64'(eirq));
        chk({tag, ".irq_any"}, 64'(IRQ_ANY), 64'(|eirq));
        chk({tag, ".data_o"},  64'(DATA_O),  64'(m_rd));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ADDR = a; DATA_I = d; WRSTB = 1'b1;
        @(negedge ACLK);
        WRSTB = 1'b0;
        check_all("wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_v, input string tag);
        ADDR = a; RDSTB = 1'b1;
        @(negedge ACLK);
        RDSTB = 1'b0;
        chk(tag, 64'(DATA_O), 64'(exp_v));
        check_all(tag);
        @(negedge ACLK);
        chk({tag, ".idle"}, 64'(DATA_O), 64'h0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst.gpio_o",  64'(GPIO_O),  64'h0);
        chk("rst.gpio_oe", 64'(GPIO_OE), 64'h0);
        chk("rst.irq",     64'(IRQ),     64'h0);
        chk("rst.irq_any", 64'(IRQ_ANY), 64'h0);
        chk("rst.data_o",  64'(DATA_O),  64'h0);
        RESET_N = 1'b1;
        @(negedge ACLK);
        check_all("rst");

        // Direction
        wr(BASE + 32'h24, 32'h0003_FFFF);
        chk("dir.oe_ch1", 64'(GPIO_OE[35:18]), 64'h3_FFFF);
        rd(BASE + 32'h24, 32'h0003_FFFF, "dir.rd");

        // Atomic output updates
        wr(BASE + 32'h00, 32'h0000_00F0);
        wr(BASE + 32'h0C, 32'h0000_000F);
        rd(BASE + 32'h00, 32'h0000_00FF, "set.rd");
        wr(BASE + 32'h10, 32'h0000_0081);
        rd(BASE + 32'h00, 32'h0000_007E, "clr.rd");
        wr(BASE + 32'h14, 32'h0000_0003);
        chk("tgl.gpio_o", 64'(GPIO_O[17:0]), 64'h7D);
        rd(BASE + 32'h00, 32'h0000_007D, "tgl.rd");
        rd(BASE + 32'h0C, 32'h0, "wo.rd");

        // Input synchroniser and rising-edge interrupt
        wr(BASE + 32'h18, 32'h1);
        GPIO_I[0] = 1'b1;
        @(negedge ACLK);
        check_all("sync.k");
        ADDR = BASE + 32'h08; RDSTB = 1'b1;
        @(negedge ACLK);
        chk("sync.din_k1", 64'(DATA_O[0]), 64'h0);
        chk("sync.irq_k1", 64'(IRQ[0]), 64'h0);
        check_all("sync.k1");
        @(negedge ACLK);
        RDSTB = 1'b0;
        chk("sync.din_k2", 64'(DATA_O[0]), 64'h1);
        chk("sync.irq_k2", 64'(IRQ[0]), 64'h1);
        chk("sync.any_k2", 64'(IRQ_ANY), 64'h1);
        check_all("sync.k2");

        // W1C and edge cases
        wr(BASE + 32'h40, 32'h1);
        chk("w1c.irq", 64'(IRQ[0]), 64'h0);
        GPIO_I[0] = 1'b0;
        repeat (4) begin
            @(negedge ACLK);
            check_all("fall_off");
        end
        chk("fall_off.irq", 64'(IRQ_ANY), 64'h0);
        GPIO_I[0] = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("race.pre", 64'(IRQ[0]), 64'h0);
        wr(BASE + 32'h40, 32'h1);
        chk("race.set_wins", 64'(IRQ[0]), 64'h1);
        wr(BASE + 32'h40, 32'h1);
        chk("race.clear", 64'(IRQ[0]), 64'h0);

        // Address handling
        wr(BASE + 32'h48, 32'hDEAD_BEEF);
        rd(BASE + 32'h48, 32'h0, "oor.rd");
        rd(BASE - 32'h4, 32'h0, "below.rd");
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        rd(BASE + 32'h00, 32'h0003_FFFF, "mask.rd");

        // Simultaneous write and read
        wr(BASE + 32'h20, 32'h5);
        ADDR = BASE + 32'h20; DATA_I = 32'hA; WRSTB = 1'b1; RDSTB = 1'b1;
        @(negedge ACLK);
        WRSTB = 1'b0; RDSTB = 1'b0;
        chk("rw.old", 64'(DATA_O), 64'h5);
        check_all("rw");
        @(negedge ACLK);
        rd(BASE + 32'h20, 32'hA, "rw.new");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            WRSTB = ($urandom_range(0, 2) == 0);
            RDSTB = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 15) == 0) ADDR = $urandom;
            else ADDR = BASE + 32'($urandom_range(0, NCHAN * 9 + 1)) * 32'd4;
            DATA_I = $urandom;
            if ($urandom_range(0, 3) == 0)
                GPIO_I = GPIO_I ^ (NW'({$urandom, $urandom}) & NW'({$urandom, $urandom}));
            @(negedge ACLK);
            check_all("rand");
        end
        WRSTB = 1'b0; RDSTB = 1'b0;

        // Asynchronous reset mid-operation
        wr(BASE + 32'h20, 32'h3_0001);
        ADDR = BASE + 32'h20; RDSTB = 1'b1;
        @(posedge ACLK);
        #2;
        chk("arst.pre", 64'(DATA_O), 64'h3_0001);
        RESET_N = 1'b0;
        #1;
        chk("arst.gpio_o",  64'(GPIO_O),  64'h0);
        chk("arst.gpio_oe", 64'(GPIO_OE), 64'h0);
        chk("arst.irq",     64'(IRQ),     64'h0);
        chk("arst.irq_any", 64'(IRQ_ANY), 64'h0);
        chk("arst.data_o",  64'(DATA_O),  64'h0);
        @(negedge ACLK);
        RDSTB = 1'b0;
        repeat (2) @(negedge ACLK);
        RESET_N = 1'b1;
        repeat (4) begin
            @(negedge ACLK);
            check_all("post_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpio_multi.md
# gpio_multi

Parametrised multi-channel memory-mapped GPIO peripheral on the core's data bus. It replaces the fixed LED/switch GPIO. Each channel has per-pin direction control, atomic set/clear/toggle of outputs, synchronised input sampling and per-pin edge-detect interrupts with write-1-to-clear status. Interrupts are reported per channel and combined into one request line.

## Interface
- BASEADDRESS, 32'h8000_0000, byte address of channel 0 register 0; must be 256-byte aligned.
- NCHAN, 2, number of channels, 1..8; each channel occupies 32 bytes.
- WIDTH, 18, pins per channel, 1..32.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.
- ACLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DATA_I  in  32  write data.
- DATA_O  out  32  registered read data.
- ADDR  in  32  byte address; bits [1:0] ignored.
- WRSTB  in  1  single-cycle write strobe.
- RDSTB  in  1  single-cycle read strobe.
- GPIO_I  in  NCHAN*WIDTH  pad inputs, asynchronous; channel c at [c*WIDTH +: WIDTH].
- GPIO_O  out  NCHAN*WIDTH  pad output values.
- GPIO_OE  out  NCHAN*WIDTH  pad output enables, 1 = drive.
- IRQ  out  NCHAN  per-channel interrupt request.
- IRQ_ANY  out  1  OR of IRQ.

## Operation
- Hit condition: BASEADDRESS <= ADDR < BASEADDRESS + NCHAN*32.
- Channel index = (ADDR-BASEADDRESS)[7:5].
- Register offset = (ADDR-BASEADDRESS)[4:2].
- Register map per channel (offsets 0..7):
  - 0 DOUT: rw.
  - 1 DIR: rw, 1 = output.
  - 2 DIN: ro, synchronised pin state. Reflects the pin regardless of DIR.
  - 3 SET: wo, DOUT |= DATA_I.
  - 4 CLR: wo, DOUT &= ~DATA_I.
  - 5 TGL: wo, DOUT ^= DATA_I.
  - 6 EDGE_CFG: rw. [15:0] rising enable, [31:16] falling enable when WIDTH <= 16. For WIDTH > 16, offset 6 = rising enable and offset 7 = STATUS is replaced: see below.
- Decided: to keep one layout for all WIDTH values, EDGE_CFG is not packed.
  - Offset 6 = RISE_EN (rw).
  - Offset 7 = FALL_EN (rw).
  - STATUS is read at channel offset 0x20*NCHAN + 4*c, the status window directly after the last channel. Writing 1 to a STATUS bit clears it.
  - The hit range therefore extends to BASEADDRESS + NCHAN*32 + NCHAN*4.
- Reads of write-only registers return 0. Bits >= WIDTH read 0 and ignore writes.
- Reads and writes outside the hit range: no register effect; DATA_O = 0.
- GPIO_O = DOUT and GPIO_OE = DIR, both registered directly.
- Edge detection: compare the last synchroniser stage with its delayed copy.
  - A rising edge sets STATUS[i] if RISE_EN[i] = 1.
  - A falling edge sets STATUS[i] if FALL_EN[i] = 1.
  - Edges are detected on all pins, including outputs.
- IRQ[c] = |STATUS[c]; IRQ_ANY = |IRQ. Both are combinational from registers.
- Simultaneous edge set and W1C clear on the same bit: set wins.
- WRSTB and RDSTB in the same cycle: both are serviced, and DATA_O returns the pre-write value.

## Timing
- Reset values: every register is 0. GPIO_O = 0, GPIO_OE = 0, IRQ = 0, IRQ_ANY = 0, DATA_O = 0. The synchroniser and edge-delay flops are also cleared.
- Write: registers update on the ACLK edge sampling WRSTB = 1. GPIO_O, GPIO_OE and IRQ change in the same edge (visible in the following cycle).
- Read: DATA_O is valid for exactly one cycle, in the cycle after RDSTB, then returns to 0. DATA_O is never tri-stated.
- Back-to-back strobes on consecutive cycles are supported.
- Input latency:
  - A GPIO_I change stable before edge k appears in DIN after edge k+SYNC_STAGES-1.
  - STATUS sets and IRQ rises one edge later, at k+SYNC_STAGES.
- Pulses shorter than one ACLK period may be missed.
- A reset assertion mid-operation clears all state immediately and asynchronously. Release is synchronous to the ACLK edge.

## Test plan
- Reset and direction:
  - Assert RESET_N = 0 → GPIO_O = 0, GPIO_OE = 0, IRQ = 0, DATA_O = 0.
  - Then write DIR ch1 = 0x3_FFFF (WIDTH 18) → GPIO_OE[35:18] = all ones next cycle.
  - Read DIR → DATA_O = 0x0003_FFFF one cycle after RDSTB, then 0.
- Atomic outputs:
  - DOUT ch0 = 0x00F0, then SET 0x000F → 0x00FF.
  - CLR 0x0081 → 0x007E.
  - TGL 0x0003 → 0x007D. Read back 0x7D.
- Input sync:
  - With SYNC_STAGES = 2, drive GPIO_I[0] 0→1 before edge k → DIN bit0 reads 1 from edge k+1.
  - With RISE_EN[0] = 1, IRQ[0] = 1 at edge k+2 and IRQ_ANY = 1.
- W1C and interrupt edge cases:
  - Write STATUS ch0 = 0x1 → IRQ[0] = 0.
  - Falling edge with FALL_EN = 0 → no IRQ.
  - Edge arriving in the same cycle as the W1C → STATUS stays 1.
- Address handling:
  - Write 0xDEAD_BEEF to BASEADDRESS + NCHAN*32 + NCHAN*4 (out of range) → no register changes, read there returns 0.
  - Write DOUT = 0xFFFF_FFFF → read back 0x0003_FFFF.
- Concurrency:
  - WRSTB and RDSTB together on DOUT (old 0x5, new 0xA) → DATA_O = 0x5, a subsequent read returns 0xA.
  - Assert RESET_N low mid-sequence → all outputs 0 within the same cycle.
